// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern source: sync/de/RGB from h/v counters,
// with the pattern selection and solid colour latched only at frame start.
module video_pattern_gen #(
    parameter int   COMPONENT_WIDTH = 8,
    parameter int   COUNTER_WIDTH   = 12,
    parameter int   FRAME_CNT_WIDTH = 16,
    parameter int   CHECKER_LOG2    = 5,
    parameter logic H_SYNC          = 1'b0,
    parameter logic V_SYNC          = 1'b0,
    parameter int   H_VISIBLE       = 640,
    parameter int   H_FRONTPORCH    = 16,
    parameter int   H_PULSE         = 96,
    parameter int   H_BACKPORCH     = 48,
    parameter int   V_VISIBLE       = 480,
    parameter int   V_FRONTPORCH    = 10,
    parameter int   V_PULSE         = 2,
    parameter int   V_BACKPORCH     = 33
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [2:0]                     pattern_sel,
    input  logic [3*COMPONENT_WIDTH-1:0]   fg_color,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           de,
    output logic [3*COMPONENT_WIDTH-1:0]   data,
    output logic                           frame_start,
    output logic [2:0]                     active_pattern,
    output logic [FRAME_CNT_WIDTH-1:0]     frame_count
);

    localparam int CW      = COMPONENT_WIDTH;
    localparam int DW      = 3 * CW;
    localparam int H_TOTAL = H_PULSE + H_FRONTPORCH + H_VISIBLE + H_BACKPORCH;
    localparam int V_TOTAL = V_PULSE + V_FRONTPORCH + V_VISIBLE + V_BACKPORCH;
    localparam int HX0     = H_PULSE + H_FRONTPORCH;
    localparam int VY0     = V_PULSE + V_FRONTPORCH;
    localparam int BAR_W   = H_VISIBLE / 8;

    typedef logic [COUNTER_WIDTH-1:0]   cnt_t;
    typedef logic [FRAME_CNT_WIDTH-1:0] fcnt_t;

    cnt_t              h_q, h_d, v_q, v_d, x, y;
    cnt_t              bar_cnt_q, bar_cnt_d;
    logic [3:0]        bar_idx_q, bar_idx_d;
    logic              h_vis, v_vis, vis, fs;
    logic [2:0]        pat_eff;
    logic [DW-1:0]     fg_eff;
    logic              hsync_q, vsync_q, de_q, fs_q;
    logic [DW-1:0]     data_q, fg_q;
    logic [2:0]        pat_q;
    fcnt_t             fcnt_q;

    function automatic logic [DW-1:0] pixel(input logic [2:0] pat, input cnt_t px, input cnt_t py,
                                            input logic [3:0] bi, input logic [DW-1:0] fg);
        logic [2*COUNTER_WIDTH-1:0] yx;
        logic [CW-1:0]              ramp;
        pixel = '0;
        yx    = {py, px};
        ramp  = CW'(px);
        case (pat)
            3'd0: pixel = DW'(yx);
            // Bar index bits map straight onto inverted G,R,B: white,yellow,cyan,green,magenta,red,blue,black
            3'd1: if (bi < 4'd8) pixel = {{CW{~bi[1]}}, {CW{~bi[2]}}, {CW{~bi[0]}}};
            3'd2: pixel = {3{ramp}};
            3'd3: pixel = (px[CHECKER_LOG2] ^ py[CHECKER_LOG2]) ? '0 : '1;
            3'd4: pixel = fg;
            3'd5: if (px == '0 || px == cnt_t'(H_VISIBLE - 1) ||
                      py == '0 || py == cnt_t'(V_VISIBLE - 1)) pixel = '1;
            default: pixel = '0;
        endcase
    endfunction

    // Out-of-window counts wrap to large values, so a single upper-bound compare suffices
    assign x       = h_q - cnt_t'(HX0);
    assign y       = v_q - cnt_t'(VY0);
    assign h_vis   = x < cnt_t'(H_VISIBLE);
    assign v_vis   = y < cnt_t'(V_VISIBLE);
    assign vis     = h_vis && v_vis;
    assign fs      = enable && (h_q == '0) && (v_q == '0);
    assign pat_eff = fs ? pattern_sel : pat_q;
    assign fg_eff  = fs ? fg_color : fg_q;

    always_comb begin
        h_d       = h_q + cnt_t'(1);
        v_d       = v_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (h_q == cnt_t'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == cnt_t'(V_TOTAL - 1)) ? '0 : v_q + cnt_t'(1);
        end
        if (h_d == cnt_t'(HX0)) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (h_vis) begin
            if (bar_cnt_q == cnt_t'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                if (bar_idx_q != 4'd8) bar_idx_d = bar_idx_q + 4'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            h_q       <= '0;
            v_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            hsync_q   <= ~H_SYNC;
            vsync_q   <= ~V_SYNC;
            de_q      <= 1'b0;
            data_q    <= '0;
            fs_q      <= 1'b0;
            // Pattern state and frame count survive a disable, but not a reset
            if (!reset_n) begin
                pat_q  <= '0;
                fg_q   <= '0;
                fcnt_q <= '0;
            end
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            hsync_q   <= (h_q < cnt_t'(H_PULSE)) ? H_SYNC : ~H_SYNC;
            vsync_q   <= (v_q < cnt_t'(V_PULSE)) ? V_SYNC : ~V_SYNC;
            de_q      <= vis;
            data_q    <= vis ? pixel(pat_eff, x, y, bar_idx_q, fg_eff) : '0;
            fs_q      <= fs;
            if (fs) begin
                pat_q  <= pattern_sel;
                fg_q   <= fg_color;
                fcnt_q <= fcnt_q + fcnt_t'(1);
            end
        end
    end

    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign de             = de_q;
    assign data           = data_q;
    assign frame_start    = fs_q;
    assign active_pattern = pat_q;
    assign frame_count    = fcnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench: a small 32x8 instance (border, reserved, frame counting, enable/reset)
// and a 640-wide, 4-line instance (sync/de counts, colour bars, checker->solid switch).
module tb_video_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: 32x8 visible, H_TOTAL=40 (HX0=6), V_TOTAL=12 (VY0=3), 480 cycles/frame
    logic        rst_a_n, en_a, hs_a, vs_a, de_a, fs_a;
    logic [2:0]  sel_a, ap_a;
    logic [23:0] fg_a, data_a;
    logic [1:0]  fc_a;

    video_pattern_gen #(
        .COMPONENT_WIDTH(8), .COUNTER_WIDTH(8), .FRAME_CNT_WIDTH(2), .CHECKER_LOG2(2),
        .H_SYNC(1'b0), .V_SYNC(1'b0),
        .H_VISIBLE(32), .H_FRONTPORCH(2), .H_PULSE(4), .H_BACKPORCH(2),
        .V_VISIBLE(8),  .V_FRONTPORCH(1), .V_PULSE(2), .V_BACKPORCH(1)
    ) dut_a (
        .clk(clk), .reset_n(rst_a_n), .enable(en_a), .pattern_sel(sel_a), .fg_color(fg_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .data(data_a), .frame_start(fs_a),
        .active_pattern(ap_a), .frame_count(fc_a)
    );

    // Instance B: default horizontal timing, 4 visible lines, V_TOTAL=18 (VY0=12), 14400 cycles/frame
    logic        rst_b_n, en_b, hs_b, vs_b, de_b, fs_b;
    logic [2:0]  sel_b, ap_b;
    logic [23:0] fg_b, data_b;
    logic [15:0] fc_b;

    video_pattern_gen #(
        .V_VISIBLE(4), .V_FRONTPORCH(10), .V_PULSE(2), .V_BACKPORCH(2)
    ) dut_b (
        .clk(clk), .reset_n(rst_b_n), .enable(en_b), .pattern_sel(sel_b), .fg_color(fg_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .data(data_b), .frame_start(fs_b),
        .active_pattern(ap_b), .frame_count(fc_b)
    );

    int          bar_x   [10] = '{0, 79, 80, 159, 160, 320, 480, 559, 560, 639};
    logic [23:0] bar_rgb [10] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h00FFFF,
                                  24'hFF00FF, 24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000};

    initial begin
        int pulses, hs_lo, vs_lo, de_n, fs_n, first_de;
        logic [23:0] first_data;
        int base2, base3, base4;

        rst_a_n = 1'b0; en_a = 1'b1; sel_a = 3'd5; fg_a = '0;
        rst_b_n = 1'b0; en_b = 1'b1; sel_b = 3'd0; fg_b = '0;

        // ---------------- Instance A ----------------
        repeat (3) tick();
        check("a_rst_hsync", hs_a, 1);
        check("a_rst_vsync", vs_a, 1);
        check("a_rst_de",    de_a, 0);
        check("a_rst_data",  data_a, 0);
        check("a_rst_fs",    fs_a, 0);
        check("a_rst_ap",    ap_a, 0);
        check("a_rst_fc",    fc_a, 0);

        rst_a_n = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 2400; k++) begin
            int kk, h, v, x, y;
            logic vis, brd;
            tick();
            kk  = k % 480;
            h   = kk % 40;
            v   = kk / 40;
            x   = h - 6;
            y   = v - 3;
            vis = (x >= 0) && (x < 32) && (y >= 0) && (y < 8);
            brd = (x == 0) || (x == 31) || (y == 0) || (y == 7);
            if (k < 480) begin
                check($sformatf("a_hs_%0d", k), hs_a, (h < 4) ? 0 : 1);
                check($sformatf("a_vs_%0d", k), vs_a, (v < 2) ? 0 : 1);
                check($sformatf("a_de_%0d", k), de_a, vis);
                check($sformatf("a_border_%0d_%0d", x, y), data_a, (vis && brd) ? 24'hFFFFFF : 24'h0);
            end
            if (k == 10) sel_a = 3'd6;
            if (k == 480) check("a_ap_reserved", ap_a, 6);
            if (k >= 480 && k < 960 && vis) check($sformatf("a_reserved_%0d", k), data_a, 0);
            if (fs_a) begin
                check($sformatf("a_fs_pos_%0d", pulses), k, pulses * 480);
                pulses++;
                check($sformatf("a_fc_%0d", pulses), fc_a, pulses % 4);
            end
        end
        check("a_fs_pulses", pulses, 5);

        for (int k = 2400; k < 2570; k++) tick();
        check("a_pre_drop_fc", fc_a, 2);
        check("a_pre_drop_de", de_a, 1);

        en_a  = 1'b0;
        sel_a = 3'd2;
        tick();
        check("a_off_hsync", hs_a, 1);
        check("a_off_vsync", vs_a, 1);
        check("a_off_de",    de_a, 0);
        check("a_off_data",  data_a, 0);
        check("a_off_fs",    fs_a, 0);
        check("a_off_fc",    fc_a, 2);
        check("a_off_ap",    ap_a, 6);
        repeat (9) tick();

        en_a = 1'b1;
        tick();
        check("a_on_fs",    fs_a, 1);
        check("a_on_fc",    fc_a, 3);
        check("a_on_hsync", hs_a, 0);
        check("a_on_vsync", vs_a, 0);
        check("a_on_ap",    ap_a, 2);
        for (int j = 1; j <= 200; j++) begin
            tick();
            if (j == 125) check("a_ramp_de_before", de_a, 0);
            if (j == 126) begin
                check("a_ramp_de", de_a, 1);
                check("a_ramp_x0", data_a, 24'h000000);
            end
            if (j == 131) check("a_ramp_x5", data_a, 24'h050505);
        end

        rst_a_n = 1'b0;
        tick();
        check("a_rst2_fc",    fc_a, 0);
        check("a_rst2_ap",    ap_a, 0);
        check("a_rst2_de",    de_a, 0);
        check("a_rst2_hsync", hs_a, 1);
        check("a_rst2_fs",    fs_a, 0);
        tick();
        rst_a_n = 1'b1;
        tick();
        check("a_rel_fs", fs_a, 1);
        check("a_rel_fc", fc_a, 1);
        check("a_rel_ap", ap_a, 2);

        // ---------------- Instance B ----------------
        check("b_rst_hsync", hs_b, 1);
        check("b_rst_vsync", vs_b, 1);
        check("b_rst_de",    de_b, 0);
        check("b_rst_data",  data_b, 0);
        check("b_rst_fc",    fc_b, 0);

        rst_b_n  = 1'b1;
        hs_lo = 0; vs_lo = 0; de_n = 0; fs_n = 0; first_de = -1; first_data = '1;
        base2 = 14400 + 9712;
        base3 = 28800 + 9712;
        base4 = 43200 + 9712;
        for (int k = 0; k <= base4 + 800; k++) begin
            tick();
            if (k < 14400) begin
                hs_lo += (hs_b == 1'b0) ? 1 : 0;
                vs_lo += (vs_b == 1'b0) ? 1 : 0;
                de_n  += de_b ? 1 : 0;
                fs_n  += fs_b ? 1 : 0;
                if (de_b && first_de < 0) begin
                    first_de   = k;
                    first_data = data_b;
                end
            end
            if (k == 0) begin
                check("b_f1_fs", fs_b, 1);
                check("b_f1_fc", fc_b, 1);
            end
            if (k == 5000) sel_b = 3'd1;
            if (k == 14399) begin
                check("b_midframe_ap", ap_b, 0);
                check("b_hsync_low",   hs_lo, 1728);
                check("b_vsync_low",   vs_lo, 1600);
                check("b_de_cycles",   de_n, 2560);
                check("b_fs_count",    fs_n, 1);
                check("b_first_de_at", first_de, 9712);
                check("b_first_data",  first_data, 0);
            end
            if (k == 14400) begin
                check("b_f2_fs", fs_b, 1);
                check("b_f2_fc", fc_b, 2);
                check("b_f2_ap", ap_b, 1);
            end
            for (int i = 0; i < 10; i++)
                if (k == base2 + bar_x[i]) check($sformatf("b_bar_x%0d", bar_x[i]), data_b, bar_rgb[i]);
            if (k == base2 + 640) begin
                check("b_bar_end_de",   de_b, 0);
                check("b_bar_end_data", data_b, 0);
            end
            if (k == 20000) sel_b = 3'd3;
            if (k == base3) begin
                check("b_chk_ap",  ap_b, 3);
                check("b_chk_0_0", data_b, 24'hFFFFFF);
            end
            if (k == base3 + 32) check("b_chk_32_0", data_b, 24'h000000);
            if (k == base3 + 64) check("b_chk_64_0", data_b, 24'hFFFFFF);
            if (k == base3 + 100) begin
                sel_b = 3'd4;
                fg_b  = 24'h123456;
            end
            if (k == base3 + 800) begin
                check("b_chk_0_1",    data_b, 24'hFFFFFF);
                check("b_chk_hold_ap", ap_b, 3);
            end
            if (k == base3 + 840) check("b_chk_40_1", data_b, 24'h000000);
            if (k == 43200) begin
                check("b_f4_fs", fs_b, 1);
                check("b_f4_fc", fc_b, 4);
                check("b_f4_ap", ap_b, 4);
            end
            if (k == base4 + 5) begin
                check("b_solid_de",   de_b, 1);
                check("b_solid_data", data_b, 24'h123456);
            end
            if (k == base4 + 700) begin
                check("b_solid_blank_de",   de_b, 0);
                check("b_solid_blank_data", data_b, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
